// File: rtl/alsu_pkg.sv
// Shared types for the ALSU pipeline: opcode and FSM state encodings plus
// the decode rule that marks an operand bundle as invalid.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MUL    = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_e;

    // Opcodes 6/7 are undefined; reductions only make sense for OR/XOR.
    function automatic logic is_invalid(input logic [2:0] op,
                                        input logic       red_a,
                                        input logic       red_b);
        return (op[2:1] == 2'b11) || ((red_a | red_b) && (op[2:1] != 2'b00));
    endfunction

endpackage

// File: rtl/alsu_serial_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks
// per product. 'done' and 'product' are valid combinationally on the last step.
module alsu_serial_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;

    // The running sum including this cycle's partial product, so the owner
    // can latch the final product on the same edge as the last iteration.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= OUT_W'(a);
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// Handshaked ALSU: OR/XOR/ADD/MUL/SHIFT/ROTATE on WIDTH-bit operands, 2*WIDTH result.
// Defining ALSU_PIPE_FLAGS_EN adds registered zero_flag and carry_flag outputs.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 4,
    parameter int    LED_W          = 16,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               err,
    output logic [LED_W-1:0]   leds
`ifdef ALSU_PIPE_FLAGS_EN
    ,
    output logic               zero_flag,
    output logic               carry_flag
`endif
);

    localparam int OUT_W   = 2 * WIDTH;
    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    state_e           state;
    logic [2:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_cin;
    logic             cap_si;
    logic             cap_dir;
    logic             cap_red_a;
    logic             cap_red_b;
    logic             cap_byp_a;
    logic             cap_byp_b;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [OUT_W-1:0] mul_product;

    logic             cap_invalid;
    logic             use_red_a;
    logic             use_red_b;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic [OUT_W-1:0] sum;
    logic [OUT_W-1:0] exec_result;
    logic             err_d;

    assign in_ready  = (state == IDLE) && !mul_busy && !reset;
    assign accept    = in_valid && in_ready;
    // Bypass and invalid bundles never enter the multiplier, even for opcode MUL.
    assign mul_start = accept && (opcode == OP_MUL)
                       && !is_invalid(opcode, red_op_A, red_op_B)
                       && !bypass_A && !bypass_B;

    alsu_serial_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (A),
        .b      (B),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    assign cap_invalid = is_invalid(cap_op, cap_red_a, cap_red_b);
    assign use_red_a   = cap_red_a && (PRIO_A || !cap_red_b);
    assign use_red_b   = cap_red_b && !use_red_a;
    assign a_ext       = OUT_W'(cap_a);
    assign b_ext       = OUT_W'(cap_b);
    // Zero-extended add keeps the carry in bit WIDTH.
    assign sum         = a_ext + b_ext + OUT_W'(cap_cin & USE_CIN);

    always_comb begin
        exec_result = '0;
        if (cap_invalid) begin
            exec_result = '0;
        end else if (cap_byp_a && (PRIO_A || !cap_byp_b)) begin
            exec_result = a_ext;
        end else if (cap_byp_b) begin
            exec_result = b_ext;
        end else begin
            case (cap_op)
                OP_OR: begin
                    if (use_red_a)      exec_result = OUT_W'(|cap_a);
                    else if (use_red_b) exec_result = OUT_W'(|cap_b);
                    else                exec_result = a_ext | b_ext;
                end
                OP_XOR: begin
                    if (use_red_a)      exec_result = OUT_W'(^cap_a);
                    else if (use_red_b) exec_result = OUT_W'(^cap_b);
                    else                exec_result = a_ext ^ b_ext;
                end
                OP_ADD:    exec_result = sum;
                OP_SHIFT:  exec_result = cap_dir ? {out[OUT_W-2:0], cap_si}
                                                 : {cap_si, out[OUT_W-1:1]};
                OP_ROTATE: exec_result = cap_dir ? {out[OUT_W-2:0], out[OUT_W-1]}
                                                 : {out[0], out[OUT_W-1:1]};
                default:   exec_result = '0;
            endcase
        end
    end

    // Next value of err, so leds can track it without lagging a cycle.
    always_comb begin
        err_d = err;
        if (state == EXEC) begin
            err_d = cap_invalid;
        end else if ((state == MUL) && mul_done) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            leds      <= '0;
            cap_op    <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_cin   <= 1'b0;
            cap_si    <= 1'b0;
            cap_dir   <= 1'b0;
            cap_red_a <= 1'b0;
            cap_red_b <= 1'b0;
            cap_byp_a <= 1'b0;
            cap_byp_b <= 1'b0;
        end else begin
            err  <= err_d;
            leds <= err_d ? ~leds : '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_op    <= opcode;
                        cap_a     <= A;
                        cap_b     <= B;
                        cap_cin   <= cin;
                        cap_si    <= serial_in;
                        cap_dir   <= direction;
                        cap_red_a <= red_op_A;
                        cap_red_b <= red_op_B;
                        cap_byp_a <= bypass_A;
                        cap_byp_b <= bypass_B;
                        state     <= mul_start ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    out       <= exec_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                MUL: begin
                    if (mul_done) begin
                        out       <= mul_product;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALSU_PIPE_FLAGS_EN
    logic exec_carry;

    assign exec_carry = (cap_op == OP_ADD) && !cap_invalid && !cap_byp_a
                        && !cap_byp_b && sum[WIDTH];

    // zero_flag starts high so it always agrees with the reset value of out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag  <= 1'b1;
            carry_flag <= 1'b0;
        end else if (state == EXEC) begin
            zero_flag  <= (exec_result == '0);
            carry_flag <= exec_carry;
        end else if ((state == MUL) && mul_done) begin
            zero_flag  <= (mul_product == '0);
            carry_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe (WIDTH=4): directed cases plus random
// bundles compared against an arithmetic reference model.
module tb_alsu_pipe;

    localparam int WIDTH = 4;
    localparam int OUT_W = 8;
    localparam int LED_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       opcode = '0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             cin = 1'b0;
    logic             serial_in = 1'b0;
    logic             direction = 1'b0;
    logic             red_op_A = 1'b0;
    logic             red_op_B = 1'b0;
    logic             bypass_A = 1'b0;
    logic             bypass_B = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out;
    logic             err;
    logic [LED_W-1:0] leds;
`ifdef ALSU_PIPE_FLAGS_EN
    logic             zero_flag;
    logic             carry_flag;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] model_out = 8'h00;

    always #5 clk = ~clk;

    alsu_pipe #(
        .WIDTH         (WIDTH),
        .LED_W         (LED_W),
        .INPUT_PRIORITY("A"),
        .FULL_ADDER    ("ON")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .serial_in (serial_in),
        .direction (direction),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .err       (err),
        .leds      (leds)
`ifdef ALSU_PIPE_FLAGS_EN
        ,
        .zero_flag (zero_flag),
        .carry_flag(carry_flag)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {err, out} from the operation rules with plain integer arithmetic.
    function automatic logic [8:0] ref_result(input int op, input int a, input int b,
                                              input int c, input int si, input int dir,
                                              input int ra, input int rb, input int ba,
                                              input int bb, input int prev);
        int r;
        if (op >= 6 || ((ra != 0 || rb != 0) && op >= 2)) return {1'b1, 8'h00};
        if (ba != 0) return {1'b0, 8'(a)};
        if (bb != 0) return {1'b0, 8'(b)};
        case (op)
            0: r = (ra != 0) ? int'(a != 0) : (rb != 0) ? int'(b != 0) : (a | b);
            1: r = (ra != 0) ? $countones(a) % 2 : (rb != 0) ? $countones(b) % 2 : (a ^ b);
            2: r = a + b + c;
            3: r = a * b;
            4: r = (dir != 0) ? (prev * 2 + si) % 256 : prev / 2 + si * 128;
            5: r = (dir != 0) ? (prev * 2) % 256 + prev / 128 : prev / 2 + (prev % 2) * 128;
            default: r = 0;
        endcase
        return {1'b0, 8'(r)};
    endfunction

    task automatic apply_stimulus(input int op, input int a, input int b, input int c,
                                  input int si, input int dir, input int ra, input int rb,
                                  input int ba, input int bb, input int stall);
        logic [8:0]  res;
        logic [15:0] prev_leds;
        logic [15:0] exp_leds;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          ready_low_ok;
        res     = ref_result(op, a, b, c, si, dir, ra, rb, ba, bb, int'(model_out));
        exp_lat = (!res[8] && op == 3 && ba == 0 && bb == 0) ? WIDTH : 1;

        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = in_ready;
        end
        check_output("ready_before_accept", 32'(seen), 32'd1);

        opcode = 3'(op); A = 4'(a); B = 4'(b); cin = 1'(c); serial_in = 1'(si);
        direction = 1'(dir); red_op_A = 1'(ra); red_op_B = 1'(rb);
        bypass_A = 1'(ba); bypass_B = 1'(bb); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 3'($urandom); A = 4'($urandom); B = 4'($urandom);
        {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = 7'($urandom);

        @(negedge clk);
        check_output("hold_before_done", {23'd0, out_valid, out}, {23'd0, 1'b0, model_out});

        lat = 0;
        ready_low_ok = 1'b1;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (in_ready) ready_low_ok = 1'b0;
            if (out_valid) lat = i;
        end
        check_output("latency", 32'(lat), 32'(exp_lat));
        check_output("ready_low_busy", 32'(ready_low_ok), 32'd1);
        check_output("result", 32'(out), 32'(res[7:0]));
        check_output("err", 32'(err), 32'(res[8]));
        check_output("leds_state", 32'((leds == '0) || (res[8] && leds == '1)), 32'd1);

        for (int s = 0; s < stall; s++) begin
            prev_leds = leds;
            in_valid  = 1'($urandom);
            @(negedge clk);
            exp_leds = res[8] ? ~prev_leds : 16'h0000;
            check_output("stall_hold", {22'd0, in_ready, out_valid, out}, {22'd0, 2'b01, res[7:0]});
            check_output("leds_toggle", 32'(leds), 32'(exp_leds));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("after_handshake", {22'd0, in_ready, out_valid, out}, {22'd0, 2'b10, res[7:0]});
        model_out = res[7:0];
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check_output("reset_ready", 32'(in_ready), 32'd0);
        check_output("reset_outs", {22'd0, out_valid, err, out}, 32'd0);
        check_output("reset_leds", 32'(leds), 32'd0);
        reset = 1'b0;
        #1;
        check_output("ready_after_reset", 32'(in_ready), 32'd1);

        apply_stimulus(2, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0, 2);
        apply_stimulus(3, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 5);
        apply_stimulus(0, 4'h0, 4'h3, 0, 0, 0, 1, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 4'h3, 0, 0, 0, 1, 1, 1, 0, 0);
        apply_stimulus(0, 4'h0, 4'h3, 0, 0, 0, 0, 0, 0, 1, 0);
        apply_stimulus(4, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply_stimulus(5, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply_stimulus(4, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1);
        apply_stimulus(6, 4'h9, 4'h2, 0, 0, 0, 0, 0, 0, 0, 4);
        apply_stimulus(1, 4'h5, 4'h3, 0, 0, 0, 0, 0, 0, 0, 2);

        // Reset pulsed during the second multiply cycle discards the product.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = in_ready;
        end
        check_output("ready_before_mul_reset", 32'(seen), 32'd1);
        opcode = 3'd3; A = 4'hF; B = 4'hF; bypass_A = 1'b0; bypass_B = 1'b0;
        red_op_A = 1'b0; red_op_B = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_output("mid_mul_reset", {21'd0, in_ready, out_valid, err, out}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("ready_after_mul_reset", {22'd0, in_ready, out_valid, out}, {22'd0, 2'b10, 8'h00});
        model_out = 8'h00;

        for (int t = 0; t < 40; t++) begin
            apply_stimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 5) == 0),
                           int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 5) == 0),
                           int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
